// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, load-return and debug
// requests toward the arbiter, plus its readys, stall and registered rf_* outputs.
interface wb_port_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          pipe_we;
  logic [AW-1:0] pipe_rd;
  logic [DW-1:0] pipe_data;

  logic          ld_valid;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          ld_ready;

  logic          dbg_valid;
  logic [AW-1:0] dbg_rd;
  logic [DW-1:0] dbg_data;
  logic          dbg_ready;

  logic          stall_req;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    grant_src;

  // Requester side: pipeline, load unit, debug port and the register file.
  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output ld_valid, ld_rd, ld_data,
    output dbg_valid, dbg_rd, dbg_data,
    input  ld_ready, dbg_ready, stall_req,
    input  rf_we, rf_waddr, rf_wdata, grant_src
  );

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  ld_valid, ld_rd, ld_data,
    input  dbg_valid, dbg_rd, dbg_data,
    output ld_ready, dbg_ready, stall_req,
    output rf_we, rf_waddr, rf_wdata, grant_src
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port: pipeline has fixed priority, load and debug
// share leftover slots round-robin, and a starvation guard forces a stall slot.
module wb_port_arbiter #(
  parameter int DW           = 8,
  parameter int AW           = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int ZERO_REG     = 1
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_LD   = 2'd2,
    SRC_DBG  = 2'd3
  } src_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]    starve_cnt;
  logic          force_slot;
  logic          rr_last_dbg;
  logic          sec_valid;
  logic          pick_dbg;
  src_e          sel;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;
  logic          sel_zero;

  always_comb begin
    sec_valid = bus.ld_valid || bus.dbg_valid;
    // On a tie debug wins only if load was the last secondary served.
    pick_dbg  = bus.dbg_valid && (!bus.ld_valid || !rr_last_dbg);

    sel = SRC_NONE;
    if (!rst) begin
      sel = SRC_NONE;
    end else if (force_slot || !bus.pipe_we) begin
      if (sec_valid) sel = pick_dbg ? SRC_DBG : SRC_LD;
    end else begin
      sel = SRC_PIPE;
    end

    sel_rd   = '0;
    sel_data = '0;
    case (sel)
      SRC_PIPE: begin sel_rd = bus.pipe_rd; sel_data = bus.pipe_data; end
      SRC_LD:   begin sel_rd = bus.ld_rd;   sel_data = bus.ld_data;   end
      SRC_DBG:  begin sel_rd = bus.dbg_rd;  sel_data = bus.dbg_data;  end
      default:  begin sel_rd = '0;          sel_data = '0;            end
    endcase

    sel_zero = (ZERO_REG != 0) && (sel_rd == '0);
  end

  assign bus.ld_ready  = (sel == SRC_LD);
  assign bus.dbg_ready = (sel == SRC_DBG);
  assign bus.stall_req = force_slot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.grant_src <= SRC_NONE;
      starve_cnt    <= '0;
      force_slot    <= 1'b0;
      rr_last_dbg   <= 1'b1;
    end else begin
      bus.rf_we     <= (sel != SRC_NONE) && !sel_zero;
      bus.grant_src <= sel;
      if (sel != SRC_NONE) begin
        bus.rf_waddr <= sel_rd;
        bus.rf_wdata <= sel_data;
      end

      if (sel == SRC_LD)       rr_last_dbg <= 1'b0;
      else if (sel == SRC_DBG) rr_last_dbg <= 1'b1;

      // The forced slot lasts one cycle and restarts the blocked-cycle count.
      force_slot <= 1'b0;
      starve_cnt <= '0;
      if (bus.pipe_we && !force_slot && sec_valid) begin
        if (starve_cnt + 4'd1 == LIMIT) force_slot <= 1'b1;
        else                            starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipe priority, round-robin,
// starvation slot, zero register and reset during a forced slot.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   n;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DW(8), .AW(3)) bus ();

  wb_port_arbiter #(
    .DW(8), .AW(3), .STARVE_LIMIT(4), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
    bus.dbg_valid = 1'b0; bus.dbg_rd = '0; bus.dbg_data = '0;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [2:0] addr,
                          input logic [7:0] data, input logic [1:0] src);
    check({tag, "_we"},   32'(bus.rf_we),     32'(we));
    check({tag, "_addr"}, 32'(bus.rf_waddr),  32'(addr));
    check({tag, "_data"}, 32'(bus.rf_wdata),  32'(data));
    check({tag, "_src"},  32'(bus.grant_src), 32'(src));
  endtask

  initial begin
    idle_inputs();

    // Reset held with random requests
    for (int i = 0; i < 3; i++) begin
      bus.pipe_we = 1'($urandom); bus.pipe_rd = 3'($urandom); bus.pipe_data = 8'($urandom);
      bus.ld_valid = 1'($urandom); bus.ld_rd = 3'($urandom); bus.ld_data = 8'($urandom);
      bus.dbg_valid = 1'($urandom); bus.dbg_rd = 3'($urandom); bus.dbg_data = 8'($urandom);
      tick();
      check("rst_rf", {bus.rf_we, bus.stall_req, bus.grant_src, bus.ld_ready, bus.dbg_ready},
            32'd0);
    end
    check_rf("rst", 1'b0, 3'd0, 8'h00, 2'd0);
    idle_inputs();
    rst = 1'b1;
    #1;
    check("idle_ready", {bus.ld_ready, bus.dbg_ready, bus.stall_req}, 32'd0);
    tick();
    check("idle_we", 32'(bus.rf_we), 32'd0);
    check("idle_src", 32'(bus.grant_src), 32'd0);

    // Pipe only
    bus.pipe_we = 1'b1; bus.pipe_rd = 3'd5; bus.pipe_data = 8'hA7;
    #1;
    check("pipe_stall", 32'(bus.stall_req), 32'd0);
    tick();
    check_rf("pipe", 1'b1, 3'd5, 8'hA7, 2'd1);
    idle_inputs();

    // Round-robin: first tie goes to load
    bus.ld_valid = 1'b1; bus.ld_rd = 3'd2; bus.ld_data = 8'h11;
    bus.dbg_valid = 1'b1; bus.dbg_rd = 3'd3; bus.dbg_data = 8'h22;
    #1;
    check("rr1_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("rr1_dbg_ready", 32'(bus.dbg_ready), 32'd0);
    tick();
    check_rf("rr1", 1'b1, 3'd2, 8'h11, 2'd2);
    // Load re-presents at once; debug now wins the tie
    bus.ld_rd = 3'd6; bus.ld_data = 8'h33;
    #1;
    check("rr2_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rr2_dbg_ready", 32'(bus.dbg_ready), 32'd1);
    tick();
    check_rf("rr2", 1'b1, 3'd3, 8'h22, 2'd3);
    bus.dbg_valid = 1'b0;
    #1;
    check("rr3_ld_ready", 32'(bus.ld_ready), 32'd1);
    tick();
    check_rf("rr3", 1'b1, 3'd6, 8'h33, 2'd2);
    idle_inputs();
    tick();
    check_rf("rr_hold", 1'b0, 3'd6, 8'h33, 2'd0);

    // Starvation: four blocked cycles then a forced load slot
    bus.pipe_we = 1'b1; bus.pipe_rd = 3'd1; bus.pipe_data = 8'h10;
    bus.ld_valid = 1'b1; bus.ld_rd = 3'd4; bus.ld_data = 8'h5C;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("starve_ld_ready", 32'(bus.ld_ready), 32'd0);
      check("starve_stall", 32'(bus.stall_req), 32'd0);
      tick();
      check("starve_src", 32'(bus.grant_src), 32'd1);
    end
    check("force_stall", 32'(bus.stall_req), 32'd1);
    check("force_ld_ready", 32'(bus.ld_ready), 32'd1);
    tick();
    check_rf("force", 1'b1, 3'd4, 8'h5C, 2'd2);
    check("force_end", 32'(bus.stall_req), 32'd0);
    bus.ld_valid = 1'b0;
    tick();
    check_rf("resume", 1'b1, 3'd1, 8'h10, 2'd1);
    idle_inputs();

    // Zero register: accepted but never written
    bus.dbg_valid = 1'b1; bus.dbg_rd = 3'd0; bus.dbg_data = 8'hFF;
    #1;
    check("zero_dbg_ready", 32'(bus.dbg_ready), 32'd1);
    tick();
    check("zero_we", 32'(bus.rf_we), 32'd0);
    check("zero_src", 32'(bus.grant_src), 32'd3);
    idle_inputs();
    tick();
    check("zero_after_src", 32'(bus.grant_src), 32'd0);

    // Reset during a forced slot
    bus.pipe_we = 1'b1; bus.pipe_rd = 3'd1; bus.pipe_data = 8'h20;
    bus.ld_valid = 1'b1; bus.ld_rd = 3'd7; bus.ld_data = 8'h99;
    for (int i = 0; i < 4; i++) tick();
    check("mid_stall", 32'(bus.stall_req), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_out", {bus.stall_req, bus.rf_we, bus.grant_src, bus.ld_ready}, 32'd0);
    check("mid_rst_cnt", 32'(dut.starve_cnt), 32'd0);
    tick();
    check("mid_rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    rst = 1'b1;
    #1;
    n = 0;
    while (!bus.stall_req && n < 10) begin
      tick();
      n++;
    end
    check("post_rst_blocked_cycles", 32'(n), 32'd4);
    check("post_rst_stall", 32'(bus.stall_req), 32'd1);
    tick();
    check_rf("post_rst", 1'b1, 3'd7, 8'h99, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between three sources:
  - the EX/WB pipeline writeback (RegWrite / ALU result / rd);
  - a multi-cycle load-return unit;
  - a debug/init write port.
- The pipeline has fixed priority. Load and debug share the remaining slots round-robin.
- A starvation guard periodically stalls the pipeline for one cycle so secondary writes always complete.

Parameters:
- DW, 8, data width of the register-file write data.
- AW, 3, register address width (2^AW registers).
- STARVE_LIMIT, 4, consecutive cycles a secondary request may be blocked by pipeline writes before a forced slot (range 1..15).
- ZERO_REG, 1, when 1, writes to address 0 are accepted but never drive rf_we.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- pipe_we  in  1  pipeline writeback enable (RegWrite from EX/WB)
- pipe_rd  in  AW  pipeline destination register
- pipe_data  in  DW  pipeline writeback data
- ld_valid  in  1  load-return request
- ld_rd  in  AW  load destination
- ld_data  in  DW  load data
- ld_ready  out  1  load write accepted this cycle
- dbg_valid  in  1  debug write request
- dbg_rd  in  AW  debug destination
- dbg_data  in  DW  debug data
- dbg_ready  out  1  debug write accepted this cycle
- stall_req  out  1  pipeline must hold EX/WB and re-present its write next cycle
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  DW  register-file write data (registered)
- grant_src  out  2  source of current rf_* write: 0 none, 1 pipe, 2 load, 3 debug (registered)

Behaviour:
- Reset (rst=0, async) sets:
  - rf_we=0, rf_waddr=0, rf_wdata=0, grant_src=0, stall_req=0;
  - starve_cnt=0, force=0;
  - rr_last=debug, so load wins the first tie.
- ld_ready and dbg_ready are 0 while rst=0.
- Handshake:
  - Requesters hold valid/rd/data stable until ready.
  - A transfer occurs when valid and ready are both 1 on a clk edge.
  - Ready is combinational from the valid inputs and internal state, and is 1 only for the granted source.
  - Valid must not depend on ready.
- Grant, evaluated each cycle:
  1. If force=1: pipe_we is ignored and stall_req=1. A secondary is granted, round-robin if both are valid.
  2. Otherwise, if pipe_we=1: pipe is granted and both readys are 0.
  3. Otherwise, if exactly one secondary is valid: that one is granted.
  4. Otherwise, if both are valid: grant the one not equal to rr_last.
  5. Otherwise: no grant.
- rr_last updates only on a secondary transfer.
- Output latency: a granted write appears on rf_we/rf_waddr/rf_wdata/grant_src on the next clk edge and is held for exactly one cycle. With no grant, rf_we=0, grant_src=0, and addr/data hold their last values.
- Zero register: if ZERO_REG=1 and the granted address is 0, the transfer completes (ready=1 for secondaries) but rf_we=0. grant_src still reports the source.
- Starvation guard:
  - starve_cnt increments when pipe_we=1, force=0 and (ld_valid or dbg_valid).
  - It clears when no secondary is valid, when pipe_we=0, or when force=1.
  - When the increment would reach STARVE_LIMIT, force is registered to 1 for the next cycle only.
  - force clears after one cycle.
  - stall_req equals force. It goes high one cycle after the limit is hit and lasts exactly one cycle.
- Stall semantics: during stall_req=1 the pipeline holds EX/WB, so the suppressed pipe write is re-presented next cycle. The arbiter drops nothing.
- Forced slot with no secondary: if the secondary drops valid before the forced slot, force still issues stall_req for that cycle, with no grant (rf_we=0).
- Same rd from pipe and a secondary in the same cycle: no merging. Writes land in grant order.
- Reset asserted mid-operation: any pending secondary request is not accepted. Requesters must re-present after reset.

Test Plan:
- Reset: hold rst=0 with random inputs -> rf_we=0, stall_req=0, grant_src=0, readys=0; after release, idle -> rf_we stays 0.
- Pipe only: pipe_we=1, pipe_rd=5, pipe_data=0xA7 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xA7, grant_src=1.
- Round-robin: ld_valid (rd=2, 0x11) and dbg_valid (rd=3, 0x22) both held, pipe_we=0:
  - load accepted first, debug second;
  - rf writes are 2/0x11 then 3/0x22 on consecutive cycles.
- Starvation (STARVE_LIMIT=4): pipe_we=1 continuously, ld_valid=1 (rd=4, 0x5C):
  - ld_ready=0 for 4 cycles, then stall_req=1 with ld_ready=1 for one cycle;
  - next cycle rf_we=1, rf_waddr=4, rf_wdata=0x5C, grant_src=2;
  - pipe writes resume afterwards.
- Zero register: dbg_valid, dbg_rd=0, dbg_data=0xFF -> dbg_ready=1 for one cycle; rf_we stays 0; grant_src=3.
- Reset mid-forced-slot: assert rst=0 while stall_req=1 -> stall_req, rf_we and starve_cnt all 0 immediately; ld_ready=0 until rst releases.
